// File: rtl/acum_prod5b_if.sv
// Bus bundle for acum_prod5b: upstream product handshake, downstream
// result handshake, abort and frame count.
interface acum_prod5b_if;
  logic        clr;
  logic [9:0]  z;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] acc;
  logic        acc_valid;
  logic        out_ready;
  logic [3:0]  cnt;

  // Master: the environment that supplies products and consumes results.
  modport master (
    output clr, z, in_valid, out_ready,
    input  in_ready, acc, acc_valid, cnt
  );

  // Slave: the accumulator block itself.
  modport slave (
    input  clr, z, in_valid, out_ready,
    output in_ready, acc, acc_valid, cnt
  );
endinterface

// File: rtl/acum_prod5b.sv
// acum_prod5b: sums LEN unsigned 10-bit products into a 14-bit result,
// presents it with a valid/ready handshake, then starts a new frame.
// All outputs come from registers or decoded state; z never reaches acc
// combinationally.
module acum_prod5b #(
  parameter int unsigned LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  acum_prod5b_if.slave  bus
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Frame length in 5 bits so LEN=16 compares correctly against a 4-bit count + 1.
  localparam logic [4:0] LEN_W = 5'(LEN);

  logic [0:0]  state_q, state_d;
  logic [13:0] acc_q,   acc_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [4:0]  cnt_inc;
  logic        accept;

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;
  assign accept  = (state_q == ST_ACC) && bus.in_valid && !bus.clr;

  // Next-state: abort first, then collect in ACC or wait for handshake in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_d = acc_q + {4'b0000, bus.z};
            cnt_d = cnt_inc[3:0];
            if (cnt_inc == LEN_W) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.acc_valid = (state_q == ST_HOLD);
  assign bus.acc       = acc_q;
  assign bus.cnt       = cnt_q;

endmodule
